// File: rtl/decompress_frame_sched.sv
// decompress_frame_sched: raster-order block sequencer for the dequant+IDCT datapath, one block in flight.
// Optional watchdog on WAIT/DRAIN enabled by defining DECOMP_WATCHDOG_EN.
module decompress_frame_sched #(
    parameter int BLK_IDX_W      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic                 frame_abort,
    input  logic [BLK_IDX_W-1:0] img_blocks_w,
    input  logic [BLK_IDX_W-1:0] img_blocks_h,
    output logic                 fetch_req,
    output logic [BLK_IDX_W-1:0] fetch_row,
    output logic [BLK_IDX_W-1:0] fetch_col,
    input  logic                 fetch_ack,
    output logic                 dec_start,
    input  logic                 dec_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BLK_IDX_W-1:0] out_row,
    output logic [BLK_IDX_W-1:0] out_col,
    output logic                 out_last,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 err_timeout
);
    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, OUTPUT, DONE, DRAIN} state_t;
    state_t state_q, state_d;
    logic [BLK_IDX_W-1:0] row_q, row_d, col_q, col_d, w_q, w_d, h_q, h_d;
    logic accept, col_end, last, wd_trip;
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be positive");
    end
    assign accept  = state_q == IDLE && frame_start && !frame_abort;
    assign col_end = col_q == w_q - BLK_IDX_W'(1);
    assign last    = col_end && row_q == h_q - BLK_IDX_W'(1);
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        w_d     = w_q;
        h_d     = h_q;
        case (state_q)
            IDLE: if (accept) begin
                w_d     = img_blocks_w;
                h_d     = img_blocks_h;
                row_d   = '0;
                col_d   = '0;
                state_d = (img_blocks_w == '0 || img_blocks_h == '0) ? DONE : FETCH;
            end
            FETCH:  state_d = frame_abort ? IDLE : fetch_ack ? START : FETCH;
            START:  state_d = frame_abort ? IDLE : WAIT;
            WAIT:   state_d = frame_abort ? DRAIN : dec_done ? OUTPUT : wd_trip ? IDLE : WAIT;
            OUTPUT: if (frame_abort) state_d = IDLE;
                else if (out_ready) begin
                    state_d = last ? DONE : FETCH;
                    col_d   = last ? col_q : col_end ? '0 : col_q + BLK_IDX_W'(1);
                    row_d   = (!last && col_end) ? row_q + BLK_IDX_W'(1) : row_q;
                end
            DONE:   state_d = IDLE;
            DRAIN:  state_d = (frame_abort || dec_done || wd_trip) ? IDLE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            w_q     <= w_d;
            h_q     <= h_d;
        end
    end
`ifdef DECOMP_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic err_q, err_d, waiting;
    assign waiting = state_q == WAIT || state_q == DRAIN;
    // abort and dec_done take precedence over a same-cycle expiry
    assign wd_trip = waiting && wd_q == WD_W'(TIMEOUT_CYCLES - 1) && !frame_abort && !dec_done;
    always_comb begin
        wd_d  = (waiting && state_d == state_q) ? wd_q + WD_W'(1) : '0;
        err_d = accept ? 1'b0 : err_q | wd_trip;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end
    assign err_timeout = err_q;
`else
    assign wd_trip     = 1'b0;
    assign err_timeout = 1'b0;
`endif
    assign fetch_req  = state_q == FETCH;
    assign fetch_row  = row_q;
    assign fetch_col  = col_q;
    assign dec_start  = state_q == START;
    assign out_valid  = state_q == OUTPUT;
    assign out_row    = row_q;
    assign out_col    = col_q;
    assign out_last   = state_q == OUTPUT && last;
    assign frame_busy = state_q != IDLE;
    assign frame_done = state_q == DONE;
endmodule

// File: tb/tb_decompress_frame_sched.sv
// tb_decompress_frame_sched: directed and randomized frames checked against a raster-order block model.
module tb_decompress_frame_sched;
    localparam int W = 8;
    logic clk = 1'b0, rst_n = 1'b0;
    logic frame_start = 1'b0, frame_abort = 1'b0, fetch_ack = 1'b0, dec_done = 1'b0, out_ready = 1'b0;
    logic [W-1:0] img_blocks_w = '0, img_blocks_h = '0;
    logic fetch_req, dec_start, out_valid, out_last, frame_busy, frame_done, err_timeout;
    logic [W-1:0] fetch_row, fetch_col, out_row, out_col;
    int total = 0, bad = 0;
    always #5 clk = ~clk;
    decompress_frame_sched #(.BLK_IDX_W(W), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_abort(frame_abort),
        .img_blocks_w(img_blocks_w), .img_blocks_h(img_blocks_h),
        .fetch_req(fetch_req), .fetch_row(fetch_row), .fetch_col(fetch_col), .fetch_ack(fetch_ack),
        .dec_start(dec_start), .dec_done(dec_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .out_last(out_last), .frame_busy(frame_busy), .frame_done(frame_done), .err_timeout(err_timeout)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    // Drives one frame with a responder model; block k of the frame is expected at (k / w, k % w).
    task automatic run_frame(input int w, input int h, input int ack_lat, input int done_lat,
                             input int stall_k, input int stall_n, input int abort_k, input int poke_k);
        int k = 0, acks = 0, pend = 0, stall = 0, starts = 0, fetches = 0, dones = 0;
        int n = w * h;
        bit aborted = 0, abort_now = 0, drained = 0, poked = 0, fin = 0, fin_next = 0;
        @(negedge clk);
        img_blocks_w = W'(w);
        img_blocks_h = W'(h);
        frame_start  = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            frame_start = 1'b0;
            frame_abort = 1'b0;
            fetch_ack   = 1'b0;
            dec_done    = 1'b0;
            out_ready   = 1'b1;
            if (drained || fin_next) begin
                chk("idle_after_frame", frame_busy, 0);
                chk("done_low_after", frame_done, 0);
                fin = 1;
                break;
            end
            if (aborted) chk("drain_busy", frame_busy, 1);
            if (fetch_req) begin
                chk("fetch_row", fetch_row, n ? k / w : 0);
                chk("fetch_col", fetch_col, n ? k % w : 0);
                if (acks == ack_lat) begin
                    fetch_ack = 1'b1;
                    acks = 0;
                    fetches++;
                end else acks++;
            end
            if (dec_start) begin
                starts++;
                chk("dec_start_seq", starts, k + 1);
                pend = done_lat;
                if (k == abort_k) abort_now = 1;
            end else if (abort_now) begin
                frame_abort = 1'b1;
                aborted = 1;
                abort_now = 0;
                pend = 3;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    dec_done = 1'b1;
                    drained = aborted;
                end
            end
            if (out_valid) begin
                chk("valid_after_abort", aborted, 0);
                chk("out_row", out_row, k / w);
                chk("out_col", out_col, k % w);
                chk("out_last", out_last, k == n - 1);
                if (k == poke_k && !poked) begin
                    frame_start  = 1'b1;
                    img_blocks_w = W'(w + 3);
                    img_blocks_h = W'(h + 2);
                    poked = 1;
                end
                if (k == stall_k && stall < stall_n) begin
                    out_ready = 1'b0;
                    stall++;
                end else k++;
            end
            if (frame_done) begin
                chk("done_after_all_blocks", k, n);
                if (n == 0) chk("empty_done_latency", cyc, 0);
                dones++;
                fin_next = 1;
            end
        end
        chk("frame_finished", fin, 1);
        chk("dec_start_count", starts, aborted ? abort_k + 1 : n);
        chk("fetch_count", fetches, aborted ? abort_k + 1 : n);
        chk("frame_done_count", dones, aborted ? 0 : 1);
`ifndef DECOMP_WATCHDOG_EN
        chk("err_timeout_tied", err_timeout, 0);
`endif
    endtask
    initial begin
        int rw, rh;
        repeat (3) @(negedge clk);
        chk("rst_fetch_req", fetch_req, 0);
        chk("rst_dec_start", dec_start, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", frame_busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_idx", {fetch_row, fetch_col, out_row, out_col}, 0);
        rst_n = 1'b1;
        run_frame(2, 2, 0, 5, -1, 0, -1, -1);
        run_frame(3, 1, 0, 2, 1, 4, -1, -1);
        run_frame(0, 5, 0, 2, -1, 0, -1, -1);
        run_frame(2, 2, 0, 4, -1, 0, 1, -1);
        run_frame(1, 2, 1, 1, -1, 0, -1, -1);
        run_frame(2, 1, 0, 3, -1, 0, -1, 0);
        for (int i = 0; i < 6; i++) begin
            rw = $urandom_range(1, 4);
            rh = $urandom_range(1, 4);
            run_frame(rw, rh, $urandom_range(0, 2), $urandom_range(1, 6),
                      $urandom_range(0, rw * rh - 1), $urandom_range(0, 3), -1, -1);
        end
`ifdef DECOMP_WATCHDOG_EN
        @(negedge clk);
        img_blocks_w = 1;
        img_blocks_h = 1;
        frame_start  = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < 20 && !dec_start; i++) begin
            fetch_ack = fetch_req;
            @(negedge clk);
        end
        fetch_ack = 1'b0;
        chk("wd_start_seen", dec_start, 1);
        repeat (16) @(negedge clk);
        chk("wd_busy_before", frame_busy, 1);
        chk("wd_err_before", err_timeout, 0);
        @(negedge clk);
        chk("wd_err_set", err_timeout, 1);
        chk("wd_idle", frame_busy, 0);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("wd_err_cleared", err_timeout, 0);
        frame_abort = 1'b1;
        @(negedge clk);
        frame_abort = 1'b0;
        chk("wd_abort_idle", frame_busy, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
